// File: rtl/key_event_scheduler.sv
// Debounces n_ch async buttons on a shared sample tick and serialises press/release events round-robin.
// Commit-to-evt_valid_o is 1 cycle when the output register is free; stalled events are held and overruns set lost_o.
module key_event_scheduler #(
  parameter int clk_freq     = 12_000_000,
  parameter int tick_freq    = 1000,
  parameter int stable_ticks = 20,
  parameter int n_ch         = 4,
  parameter int cw           = (n_ch > 1) ? $clog2(n_ch) : 1
) (
  input  logic            clk,
  input  logic            areset_n,
  input  logic [n_ch-1:0] raw_i,
  output logic [n_ch-1:0] state_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [cw-1:0]   evt_ch_o,
  output logic            evt_press_o,
  output logic            lost_o,
  input  logic            clr_lost_i
);

  localparam int TICK_DIV = (clk_freq / tick_freq < 2) ? 2 : clk_freq / tick_freq;
  localparam int TW       = $clog2(TICK_DIV);
  localparam int CNT_W    = (stable_ticks > 1) ? $clog2(stable_ticks) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(stable_ticks - 1);
  localparam logic [cw-1:0]    CH_LAST   = cw'(n_ch - 1);

  logic [n_ch-1:0]  sync_a, sync_b;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt [n_ch];
  logic [n_ch-1:0]  commit;
  logic [n_ch-1:0]  pend, pend_pol;
  logic [n_ch-1:0]  gnt_mask;
  logic [cw-1:0]    ptr, gnt;
  logic             gnt_hit, load, lost_set;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_i;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    commit = '0;
    for (int i = 0; i < n_ch; i++) begin
      commit[i] = tick && (sync_b[i] != state_o[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Any tick sample that matches the committed level restarts that channel's count.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_o <= '0;
      for (int i = 0; i < n_ch; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < n_ch; i++) begin
        if (sync_b[i] == state_o[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          state_o[i] <= sync_b[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign load = !evt_valid_o || evt_ready_i;

  // Round-robin scan over the registered pend flags, starting at ptr.
  always_comb begin
    int j;
    logic [cw-1:0] idx;
    j       = 0;
    idx     = '0;
    gnt_hit = 1'b0;
    gnt     = '0;
    for (int k = 0; k < n_ch; k++) begin
      j = int'(ptr) + k;
      if (j >= n_ch) j = j - n_ch;
      idx = cw'(j);
      if (!gnt_hit && pend[idx]) begin
        gnt_hit = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    gnt_mask = '0;
    if (load && gnt_hit) gnt_mask[gnt] = 1'b1;
  end

  // A commit landing on the channel being granted this cycle is a fresh event, not an overrun.
  assign lost_set = |(commit & pend & ~gnt_mask);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pend     <= '0;
      pend_pol <= '0;
    end else begin
      pend     <= (pend & ~gnt_mask) | commit;
      pend_pol <= (pend_pol & ~commit) | (sync_b & commit);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      evt_valid_o <= 1'b0;
      evt_ch_o    <= '0;
      evt_press_o <= 1'b0;
      ptr         <= '0;
      lost_o      <= 1'b0;
    end else begin
      if (load) begin
        if (gnt_hit) begin
          evt_valid_o <= 1'b1;
          evt_ch_o    <= gnt;
          evt_press_o <= pend_pol[gnt];
          ptr         <= (gnt == CH_LAST) ? '0 : gnt + cw'(1);
        end else begin
          evt_valid_o <= 1'b0;
        end
      end
      if (clr_lost_i) begin
        lost_o <= 1'b0;
      end else if (lost_set) begin
        lost_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed scenarios plus randomized traffic, checked each cycle against an event-level reference model.
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic [3:0] raw = 4'b0;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] state_o;
  logic       evt_valid_o;
  logic [1:0] evt_ch_o;
  logic       evt_press_o;
  logic       lost_o;

  always #5 clk = ~clk;

  key_event_scheduler #(
    .clk_freq(1000), .tick_freq(100), .stable_ticks(3), .n_ch(4)
  ) dut (
    .clk(clk), .areset_n(areset_n), .raw_i(raw), .state_o(state_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(rdy), .evt_ch_o(evt_ch_o),
    .evt_press_o(evt_press_o), .lost_o(lost_o), .clr_lost_i(clr)
  );

  // reference model: levels seen by the debouncer, runs of differing ticks, pending events, presented event
  int       m_phase;
  bit [3:0] m_s1, m_s2, m_st, m_pend, m_pol;
  int       m_run [4];
  bit       m_valid, m_press, m_lost;
  int       m_ch, m_ptr;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int obs_ch[$], obs_pr[$], obs_cy[$];

  task automatic model_reset();
    m_phase = 0; m_s1 = 0; m_s2 = 0; m_st = 0; m_pend = 0; m_pol = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_valid = 0; m_press = 0; m_lost = 0; m_ch = 0; m_ptr = 0;
  endtask

  task automatic model_edge();
    bit [3:0] cm, pend_old;
    bit lost_set, load;
    int g, c;
    if (!areset_n) begin
      model_reset();
      return;
    end
    cm = 0;
    if (m_phase == 9) begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == 3) begin
            cm[i] = 1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    pend_old = m_pend;
    load = !m_valid || rdy;
    g = -1;
    if (load) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && pend_old[c]) g = c;
      end
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_press = m_pol[g];
        m_ptr = (g + 1) % 4; m_pend[g] = 0;
      end else begin
        m_valid = 0;
      end
    end
    lost_set = 0;
    for (int i = 0; i < 4; i++) begin
      if (cm[i]) begin
        if (pend_old[i] && g != i) lost_set = 1;
        m_pend[i] = 1; m_pol[i] = m_s2[i]; m_st[i] = m_s2[i];
      end
    end
    if (clr) m_lost = 0;
    else if (lost_set) m_lost = 1;
    m_s2 = m_s1;
    m_s1 = raw;
    m_phase = (m_phase + 1) % 10;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("state", {28'b0, state_o}, {28'b0, m_st});
    check("valid", {31'b0, evt_valid_o}, {31'b0, m_valid});
    check("ch", {30'b0, evt_ch_o}, m_ch);
    check("press", {31'b0, evt_press_o}, {31'b0, m_press});
    check("lost", {31'b0, lost_o}, {31'b0, m_lost});
  endtask

  task automatic cyc();
    if (areset_n && evt_valid_o && rdy) begin
      obs_ch.push_back(int'(evt_ch_o));
      obs_pr.push_back(int'(evt_press_o));
      obs_cy.push_back(cycle);
    end
    model_edge();
    @(negedge clk);
    cycle++;
    check_outputs();
  endtask

  task automatic clear_obs();
    obs_ch.delete(); obs_pr.delete(); obs_cy.delete();
  endtask

  task automatic assert_reset();
    areset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("rst_all_zero", {25'b0, state_o, evt_valid_o, evt_press_o, lost_o}, 32'b0);
  endtask

  task automatic wait_state(int ch, bit lvl, int budget, output int n);
    n = 0;
    while (state_o[ch] !== lvl && n < budget) begin
      cyc();
      n++;
    end
    check("wait_state", {31'b0, state_o[ch] === lvl}, 32'd1);
  endtask

  task automatic wait_valid(int budget, output int n);
    n = 0;
    while (evt_valid_o !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check("wait_valid", {31'b0, evt_valid_o === 1'b1}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1);
  end

  initial begin
    int n, nv;
    model_reset();
    @(negedge clk);
    repeat (3) cyc();

    // reset while a count is in flight
    areset_n = 1'b1; raw = 4'b0001;
    repeat (15) cyc();
    raw = 4'b0000;
    assert_reset();
    repeat (2) cyc();
    areset_n = 1'b1;
    nv = 0;
    repeat (40) begin cyc(); if (evt_valid_o) nv++; end
    check("rst_no_event", nv, 0);

    // simultaneous rise on all channels under backpressure
    clear_obs(); rdy = 1'b0; raw = 4'hF;
    wait_valid(60, n);
    repeat (5) begin
      cyc();
      check("rr_stall_ch", {30'b0, evt_ch_o}, 0);
      check("rr_stall_vld", {31'b0, evt_valid_o}, 1);
    end
    rdy = 1'b1;
    repeat (6) cyc();
    check("rr_count", obs_ch.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < obs_ch.size()) begin
        check("rr_order", obs_ch[k], k);
        check("rr_press", obs_pr[k], 1);
        if (k > 0) check("rr_consecutive", obs_cy[k] - obs_cy[k-1], 1);
      end
    end
    raw = 4'h0;
    repeat (60) cyc();

    // single press and release on ch2
    clear_obs(); raw[2] = 1'b1;
    wait_state(2, 1'b1, 60, n);
    check("press_lat_min", {31'b0, n >= 23}, 1);
    check("press_lat_max", {31'b0, n <= 32}, 1);
    cyc();
    check("press_vld", {31'b0, evt_valid_o}, 1);
    check("press_ch", {30'b0, evt_ch_o}, 2);
    check("press_pol", {31'b0, evt_press_o}, 1);
    cyc();
    check("press_pulse", {31'b0, evt_valid_o}, 0);
    raw[2] = 1'b0;
    wait_state(2, 1'b0, 60, n);
    cyc();
    check("rel_vld", {31'b0, evt_valid_o}, 1);
    check("rel_ch", {30'b0, evt_ch_o}, 2);
    check("rel_pol", {31'b0, evt_press_o}, 0);
    repeat (3) cyc();

    // bounce on ch1 then settle high
    clear_obs(); nv = 0;
    for (int t = 0; t < 100; t++) begin
      if (t % 15 == 0) raw[1] = ~raw[1];
      cyc();
      if (evt_valid_o) nv++;
    end
    check("bounce_quiet", nv, 0);
    wait_state(1, 1'b1, 60, n);
    repeat (3) cyc();
    check("bounce_events", obs_ch.size(), 1);
    if (obs_ch.size() > 0) begin
      check("bounce_ch", obs_ch[0], 1);
      check("bounce_pol", obs_pr[0], 1);
    end

    // overrun: ch2 commits twice while ch0 is stalled
    clear_obs(); rdy = 1'b0; raw[0] = 1'b1;
    wait_valid(60, n);
    check("ovf_ch0", {30'b0, evt_ch_o}, 0);
    raw[2] = 1'b1;
    wait_state(2, 1'b1, 60, n);
    raw[2] = 1'b0;
    wait_state(2, 1'b0, 60, n);
    cyc();
    check("ovf_lost", {31'b0, lost_o}, 1);
    check("ovf_hold_ch", {30'b0, evt_ch_o}, 0);
    rdy = 1'b1;
    repeat (3) cyc();
    check("ovf_events", obs_ch.size(), 2);
    if (obs_ch.size() > 1) begin
      check("ovf_ch2", obs_ch[1], 2);
      check("ovf_pol", obs_pr[1], 0);
    end
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_lost", {31'b0, lost_o}, 0);
    cyc();

    // clear held across an overwrite wins
    rdy = 1'b0; raw[0] = 1'b0;
    wait_valid(60, n);
    clr = 1'b1; raw[3] = 1'b1;
    wait_state(3, 1'b1, 60, n);
    raw[3] = 1'b0;
    wait_state(3, 1'b0, 60, n);
    cyc();
    check("clr_wins", {31'b0, lost_o}, 0);
    clr = 1'b0; rdy = 1'b1;
    repeat (5) cyc();

    // randomized traffic with stall bursts
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 59) == 0) raw[i] = ~raw[i];
      if (t % 400 < 150) rdy = ($urandom_range(0, 7) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      cyc();
    end
    clr = 1'b0;

    // reset discards presented and pending events
    rdy = 1'b0; raw = ~m_st;
    wait_valid(60, n);
    raw = 4'h0;
    assert_reset();
    repeat (2) cyc();
    areset_n = 1'b1;
    nv = 0;
    repeat (40) begin cyc(); if (evt_valid_o) nv++; end
    check("rst2_no_event", nv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_event_scheduler.md
# key_event_scheduler

Multi-channel push-button front end: synchronises and debounces `n_ch` raw inputs using one shared sample-tick generator. It converts each committed level change into a press or release event. A round-robin scheduler serialises the events onto a single valid/ready stream. It sits between board-level buttons and the UI/command logic, in place of per-input free-running filter counters.

## Interface
- `clk_freq`, default 12_000_000: clk frequency in Hz.
- `tick_freq`, default 1000: sample-tick rate in Hz. `tick_div = clk_freq / tick_freq`, minimum 2.
- `stable_ticks`, default 20: consecutive ticks an input must differ from its committed state before the change is accepted. Minimum 1.
- `n_ch`, default 4: number of channels, 1..16. `cw = max(1, $clog2(n_ch))`.

Ports:
- `clk` in 1: clock.
- `areset_n` in 1: reset, asynchronous, active-low.
- `raw_i` in n_ch: asynchronous raw button levels.
- `state_o` out n_ch: committed debounced levels.
- `evt_valid_o` out 1: event available.
- `evt_ready_i` in 1: consumer accepts the event.
- `evt_ch_o` out cw: channel index of the event.
- `evt_press_o` out 1: 1 means a 0→1 commit (press), 0 means a 1→0 commit (release).
- `lost_o` out 1: sticky flag; an undelivered event was overwritten.
- `clr_lost_i` in 1: clears `lost_o`.

## Operation
- Reset value 0 for all of: sync FFs, tick counter, per-channel counters, `state_o`, pending flags, `evt_valid_o`, `evt_ch_o`, `evt_press_o`, `lost_o`. The round-robin pointer resets to channel 0 as the first candidate.
- Each `raw_i` bit passes through 2 FFs (`sync`).
- Tick generator: counter 0..tick_div-1, wraps to 0. `tick` is combinationally high while counter == tick_div-1. There is one tick per tick_div cycles.
- Per channel, on tick only:
  - sync == state: clear the per-channel counter.
  - sync != state and cnt < stable_ticks-1: increment cnt.
  - sync != state and cnt == stable_ticks-1: set state to sync, clear cnt, set pend, set pend_pol to sync.
- Counter width is `$clog2(stable_ticks)`, minimum 1. The counter never wraps.
- Double commit: a commit on a channel whose pend is already set overwrites pend_pol and sets `lost_o`.
- Output register load happens when `!evt_valid_o || evt_ready_i`:
  - Scan pend from the pointer upward, wrapping modulo n_ch. Take the first set channel.
  - Load `evt_ch_o` and `evt_press_o`, set `evt_valid_o`, clear that pend, and move the pointer to grant+1 modulo n_ch.
  - If no pend is set, `evt_valid_o` goes to 0.
- A channel's pend committed in the same cycle it is scanned is not visible until the next cycle. A commit in the same cycle its old pend is granted leaves pend set, with the new polarity, and does not set `lost_o`.
- While `evt_valid_o && !evt_ready_i`, `evt_ch_o` and `evt_press_o` are held stable.
- `clr_lost_i` wins over a simultaneous set of `lost_o`.
- Deasserting `areset_n` at any point aborts all in-flight counts and discards all pending and presented events.

## Timing
- raw edge to `sync`: 2 cycles.
- raw edge (held stable) to `state_o` change: between (stable_ticks-1)·tick_div+3 and stable_ticks·tick_div+2 cycles.
- `state_o` change to `evt_valid_o` for that event: 1 cycle when the output register is free. Otherwise it waits for preceding grants.
- Throughput: 1 event per cycle when `evt_ready_i` is held high.
- Glitches shorter than one tick period may be missed entirely. Any sample equal to the committed state restarts the count.

## Test plan
Parameters for all scenarios: clk_freq=1000, tick_freq=100 (tick_div=10), stable_ticks=3, n_ch=4.
- **Reset:** apply reset mid-count with raw_i=4'b0001. Required: all outputs 0, and no event within 40 cycles after release unless raw is still stable.
- **Single press/release:** raise raw_i[2] and hold, with ready=1. Required: `state_o[2]` rises 23..32 cycles later. One cycle after that, a valid pulse appears with ch=2, press=1. Lowering raw_i[2] produces ch=2, press=0.
- **Bounce:** toggle raw_i[1] every 15 cycles for 100 cycles, then hold high. Required: no event during bouncing, then exactly one press event for ch=1.
- **Round-robin with backpressure:** raise raw_i[3:0] in the same cycle, with ready=0. Hold ready low for 5 cycles after valid, then set ready=1. Required: ch0 is held stable while stalled, then events arrive in order ch0, ch1, ch2, ch3, all press=1, on 4 consecutive cycles.
- **Overflow:** with ready=0, hold ch0 presented. Commit press then release on ch2. Required: `lost_o`=1. After release, the ch2 event has press=0. Asserting `clr_lost_i` for 1 cycle clears `lost_o`.
- **Simultaneous clear and set:** assert `clr_lost_i` in the same cycle as an overwrite. Required: `lost_o`=0.
